psl_responder: RTL and testbench

PSL-side command responder for the CAPI AFU interface. It accepts the commands an AFU drives on its command port, moves line data through the AFU's buffer read/write ports against a small internal backing memory, and returns tagged responses with credits. It is the other end of the AFU's command/buffer/response protocol. It serves as the bench-and-emulation host model that lets the AFU stack run without a real PSL.

---
 rtl/psl_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_psl_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psl_responder.sv
// psl_responder: PSL-side host model for the CAPI AFU command / buffer /
// response protocol. Commands queue in a FIFO, line data moves through the
// AFU buffer ports against a local line memory, and each accepted command
// gets one tagged response with a single credit.
module psl_responder #(
  parameter int CMD_DEPTH = 16,
  parameter int MEM_LINES = 256,
  parameter int BRLAT     = 2
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         command_valid,
  input  logic [7:0]   command_tag,
  input  logic [12:0]  command_code,
  input  logic [63:0]  command_address,
  input  logic [11:0]  command_size,
  output logic [7:0]   room,
  output logic         buffer_write_valid,
  output logic [7:0]   buffer_write_tag,
  output logic [5:0]   buffer_write_address,
  output logic [511:0] buffer_write_data,
  output logic         buffer_read_valid,
  output logic [7:0]   buffer_read_tag,
  output logic [5:0]   buffer_read_address,
  input  logic [511:0] buffer_read_data,
  output logic         response_valid,
  output logic [7:0]   response_tag,
  output logic [7:0]   response_code,
  output logic [8:0]   response_credits,
  output logic         overflow
);

  localparam int LW = $clog2(MEM_LINES);
  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH + 1);

  localparam logic [12:0] CODE_READ  = 13'h0A00;
  localparam logic [12:0] CODE_WRITE = 13'h0D00;
  localparam logic [7:0]  RC_DONE    = 8'h00;
  localparam logic [7:0]  RC_AERROR  = 8'h01;
  localparam logic [7:0]  RC_FAILED  = 8'h08;

  typedef struct packed {
    logic [7:0]  tag;
    logic [12:0] code;
    logic [63:0] address;
    logic [11:0] size;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, BW0, BW1, BR0, BR1, BRWAIT, RESP} state_t;

  cmd_t          fifo [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;
  cmd_t          head;

  // Line layout: byte 0 sits in the most significant byte of half 0.
  logic [1023:0] mem [MEM_LINES];
  logic [LW-1:0] head_line, rd_line;
  logic [1023:0] rd_line_data;
  logic          code_known, addr_size_ok;

  state_t        state, state_nxt;
  logic [7:0]    cur_tag, cur_tag_nxt;
  logic [7:0]    cur_code, cur_code_nxt;
  logic [LW-1:0] cur_line, cur_line_nxt;

  logic [BRLAT-1:0] rd_pipe_v, rd_pipe_a;
  logic             cap_h0, cap_h1;
  logic [511:0]     h0_data;

  logic         bw_valid_nxt, bw_half_nxt, br_valid_nxt, br_half_nxt, rsp_valid_nxt;
  logic [511:0] bw_data_nxt;

  assign room = 8'(CMD_DEPTH);

  assign full = (count == CW'(CMD_DEPTH));
  assign pop  = (state == IDLE) && (count != '0);
  assign push = command_valid && (!full || pop);
  assign head = fifo[rd_ptr];

  assign head_line    = head.address[7 +: LW];
  assign rd_line      = (state == IDLE) ? head_line : cur_line;
  assign rd_line_data = mem[rd_line];
  assign code_known   = (head.code == CODE_READ) || (head.code == CODE_WRITE);
  assign addr_size_ok = (head.address[6:0] == '0) &&
                        ((head.address >> (7 + LW)) == '0) &&
                        (head.size == 12'd128);

  // The delayed request marker tells which half the read bus carries now.
  assign cap_h0 = rd_pipe_v[BRLAT-1] && !rd_pipe_a[BRLAT-1];
  assign cap_h1 = rd_pipe_v[BRLAT-1] &&  rd_pipe_a[BRLAT-1];

  // Command FIFO storage (data only, pointers carry validity)
  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= {command_tag, command_code, command_address, command_size};
  end

  // Command FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(CMD_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(CMD_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      if (command_valid && !push) overflow <= 1'b1;
    end
  end

  // Buffer-read latency tracker and half-0 holding register
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_pipe_v <= '0;
      rd_pipe_a <= '0;
      h0_data   <= '0;
    end else begin
      rd_pipe_v[0] <= buffer_read_valid;
      rd_pipe_a[0] <= buffer_read_address[0];
      for (int unsigned i = 1; i < BRLAT; i++) begin
        rd_pipe_v[i] <= rd_pipe_v[i-1];
        rd_pipe_a[i] <= rd_pipe_a[i-1];
      end
      if (cap_h0) h0_data <= buffer_read_data;
    end
  end

  // Line commit on the half-1 capture; a reset clears the tracker so nothing lands
  always_ff @(posedge clock) begin
    if (cap_h1) mem[cur_line] <= {h0_data, buffer_read_data};
  end

  // FSM state and per-command context registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cur_tag  <= '0;
      cur_code <= '0;
      cur_line <= '0;
    end else begin
      state    <= state_nxt;
      cur_tag  <= cur_tag_nxt;
      cur_code <= cur_code_nxt;
      cur_line <= cur_line_nxt;
    end
  end

  // Next state plus the values the output registers load for the next cycle
  always_comb begin
    state_nxt     = state;
    cur_tag_nxt   = cur_tag;
    cur_code_nxt  = cur_code;
    cur_line_nxt  = cur_line;
    bw_valid_nxt  = 1'b0;
    bw_half_nxt   = 1'b0;
    bw_data_nxt   = '0;
    br_valid_nxt  = 1'b0;
    br_half_nxt   = 1'b0;
    rsp_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          cur_tag_nxt  = head.tag;
          cur_line_nxt = head_line;
          cur_code_nxt = RC_DONE;
          if (!code_known) begin
            cur_code_nxt  = RC_FAILED;
            rsp_valid_nxt = 1'b1;
            state_nxt     = RESP;
          end else if (!addr_size_ok) begin
            cur_code_nxt  = RC_AERROR;
            rsp_valid_nxt = 1'b1;
            state_nxt     = RESP;
          end else if (head.code == CODE_READ) begin
            bw_valid_nxt = 1'b1;
            bw_data_nxt  = rd_line_data[1023:512];
            state_nxt    = BW0;
          end else begin
            br_valid_nxt = 1'b1;
            state_nxt    = BR0;
          end
        end
      end
      BW0: begin
        bw_valid_nxt = 1'b1;
        bw_half_nxt  = 1'b1;
        bw_data_nxt  = rd_line_data[511:0];
        state_nxt    = BW1;
      end
      BW1: begin
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      BR0: begin
        br_valid_nxt = 1'b1;
        br_half_nxt  = 1'b1;
        state_nxt    = BR1;
      end
      BR1: state_nxt = BRWAIT;
      BRWAIT: begin
        if (cap_h1) begin
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; tag/code/data fields read zero while their strobe is low
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      buffer_write_valid   <= 1'b0;
      buffer_write_tag     <= '0;
      buffer_write_address <= '0;
      buffer_write_data    <= '0;
      buffer_read_valid    <= 1'b0;
      buffer_read_tag      <= '0;
      buffer_read_address  <= '0;
      response_valid       <= 1'b0;
      response_tag         <= '0;
      response_code        <= '0;
      response_credits     <= '0;
    end else begin
      buffer_write_valid   <= bw_valid_nxt;
      buffer_write_tag     <= bw_valid_nxt ? cur_tag_nxt : '0;
      buffer_write_address <= {5'b0, bw_half_nxt};
      buffer_write_data    <= bw_data_nxt;
      buffer_read_valid    <= br_valid_nxt;
      buffer_read_tag      <= br_valid_nxt ? cur_tag_nxt : '0;
      buffer_read_address  <= {5'b0, br_half_nxt};
      response_valid       <= rsp_valid_nxt;
      response_tag         <= rsp_valid_nxt ? cur_tag_nxt : '0;
      response_code        <= rsp_valid_nxt ? cur_code_nxt : '0;
      response_credits     <= rsp_valid_nxt ? 9'd1 : '0;
    end
  end

endmodule

// File: tb/tb_psl_responder.sv
// tb_psl_responder: directed bench for psl_responder with an AFU-side
// read-data responder and a response / buffer-traffic recorder.
module tb_psl_responder;

  localparam int BRLAT = 2;
  localparam logic [12:0] READ  = 13'h0A00;
  localparam logic [12:0] WRITE = 13'h0D00;

  logic         clock = 1'b0;
  logic         rstn;
  logic         command_valid;
  logic [7:0]   command_tag;
  logic [12:0]  command_code;
  logic [63:0]  command_address;
  logic [11:0]  command_size;
  logic [7:0]   room;
  logic         buffer_write_valid;
  logic [7:0]   buffer_write_tag;
  logic [5:0]   buffer_write_address;
  logic [511:0] buffer_write_data;
  logic         buffer_read_valid;
  logic [7:0]   buffer_read_tag;
  logic [5:0]   buffer_read_address;
  logic [511:0] buffer_read_data = '0;
  logic         response_valid;
  logic [7:0]   response_tag;
  logic [7:0]   response_code;
  logic [8:0]   response_credits;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [511:0] afu_h0 = '0;
  logic [511:0] afu_h1 = '0;
  logic [BRLAT:0] hv = '0;
  logic [BRLAT:0] ha = '0;

  logic [7:0]   rsp_tag  [64];
  logic [7:0]   rsp_code [64];
  logic [8:0]   rsp_cred [64];
  int           rsp_cyc  [64];
  int           rsp_n = 0;
  logic [7:0]   bw_tag   [64];
  logic [5:0]   bw_addr  [64];
  logic [511:0] bw_data  [64];
  int           bw_n = 0;
  logic [7:0]   br_tag   [64];
  logic [5:0]   br_addr  [64];
  int           br_cyc   [64];
  int           br_n = 0;

  psl_responder #(.CMD_DEPTH(16), .MEM_LINES(256), .BRLAT(BRLAT)) dut (
    .clock(clock), .rstn(rstn),
    .command_valid(command_valid), .command_tag(command_tag),
    .command_code(command_code), .command_address(command_address),
    .command_size(command_size), .room(room),
    .buffer_write_valid(buffer_write_valid), .buffer_write_tag(buffer_write_tag),
    .buffer_write_address(buffer_write_address), .buffer_write_data(buffer_write_data),
    .buffer_read_valid(buffer_read_valid), .buffer_read_tag(buffer_read_tag),
    .buffer_read_address(buffer_read_address), .buffer_read_data(buffer_read_data),
    .response_valid(response_valid), .response_tag(response_tag),
    .response_code(response_code), .response_credits(response_credits),
    .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // AFU side: return the requested half exactly BRLAT cycles after each request
  always @(negedge clock) begin
    for (int i = BRLAT; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = buffer_read_valid;
    ha[0] = buffer_read_address[0];
    if (hv[BRLAT]) buffer_read_data = ha[BRLAT] ? afu_h1 : afu_h0;
    else           buffer_read_data = '0;
  end

  // Record every response and buffer transfer mid-cycle
  always @(negedge clock) begin
    if (response_valid && rsp_n < 64) begin
      rsp_tag[rsp_n] = response_tag; rsp_code[rsp_n] = response_code;
      rsp_cred[rsp_n] = response_credits; rsp_cyc[rsp_n] = cyc;
      rsp_n++;
    end
    if (buffer_write_valid && bw_n < 64) begin
      bw_tag[bw_n] = buffer_write_tag; bw_addr[bw_n] = buffer_write_address;
      bw_data[bw_n] = buffer_write_data;
      bw_n++;
    end
    if (buffer_read_valid && br_n < 64) begin
      br_tag[br_n] = buffer_read_tag; br_addr[br_n] = buffer_read_address;
      br_cyc[br_n] = cyc;
      br_n++;
    end
  end

  task automatic send_cmd(input logic [7:0] tag, input logic [12:0] code,
                          input logic [63:0] addr, input logic [11:0] size, output int c);
    @(posedge clock); #1;
    command_valid = 1'b1; command_tag = tag; command_code = code;
    command_address = addr; command_size = size;
    c = cyc;
  endtask

  task automatic idle_cmd();
    @(posedge clock); #1;
    command_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && rsp_n < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; command_valid = 1'b0; command_tag = '0; command_code = '0;
    command_address = '0; command_size = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (room !== 8'd16) begin errors++; $display("FAIL rst_room: got %0d expected 16", room); end
    checks++; if ({buffer_write_valid, buffer_write_tag, buffer_write_address, buffer_write_data,
                   buffer_read_valid, buffer_read_tag, buffer_read_address, response_valid,
                   response_tag, response_code, response_credits, overflow} !== '0) begin
      errors++; $display("FAIL rst_outputs: got nonzero output expected all zero");
    end
    rstn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (room !== 8'd16) begin errors++; $display("FAIL post_rst_room: got %0d expected 16", room); end
    checks++; if ({response_valid, buffer_write_valid, buffer_read_valid, overflow} !== 4'b0) begin
      errors++; $display("FAIL post_rst_strobes: got %b expected 0000",
                         {response_valid, buffer_write_valid, buffer_read_valid, overflow});
    end
  endtask

  task automatic test_write_read();
    int c0, c1, rb, wb, qb;
    rb = rsp_n; wb = bw_n; qb = br_n;
    afu_h0 = {64{8'hAA}}; afu_h1 = {64{8'hBB}};
    send_cmd(8'h05, WRITE, 64'h80, 12'd128, c0);
    send_cmd(8'h06, READ,  64'h80, 12'd128, c1);
    idle_cmd();
    wait_rsp(rb + 2, 60);
    checks++; if (rsp_n - rb !== 2) begin errors++; $display("FAIL wr_rsp_count: got %0d expected 2", rsp_n - rb); end
    checks++; if (br_n - qb !== 2) begin errors++; $display("FAIL wr_req_count: got %0d expected 2", br_n - qb); end
    checks++; if (br_tag[qb] !== 8'h05 || br_addr[qb] !== 6'd0 || br_cyc[qb] - c0 !== 2) begin
      errors++; $display("FAIL wr_req0: got tag %0h addr %0d at +%0d expected 05 0 +2", br_tag[qb], br_addr[qb], br_cyc[qb] - c0);
    end
    checks++; if (br_tag[qb+1] !== 8'h05 || br_addr[qb+1] !== 6'd1 || br_cyc[qb+1] - c0 !== 3) begin
      errors++; $display("FAIL wr_req1: got tag %0h addr %0d at +%0d expected 05 1 +3", br_tag[qb+1], br_addr[qb+1], br_cyc[qb+1] - c0);
    end
    checks++; if (rsp_tag[rb] !== 8'h05 || rsp_code[rb] !== 8'h00) begin
      errors++; $display("FAIL wr_rsp: got tag %0h code %0h expected 05 00", rsp_tag[rb], rsp_code[rb]);
    end
    checks++; if (rsp_cyc[rb] - c0 !== 6) begin errors++; $display("FAIL wr_rsp_cycle: got %0d expected 6", rsp_cyc[rb] - c0); end
    checks++; if (rsp_tag[rb+1] !== 8'h06 || rsp_code[rb+1] !== 8'h00 || rsp_cyc[rb+1] - c0 !== 10) begin
      errors++; $display("FAIL rd_rsp: got tag %0h code %0h at +%0d expected 06 00 +10", rsp_tag[rb+1], rsp_code[rb+1], rsp_cyc[rb+1] - c0);
    end
    checks++; if (bw_n - wb !== 2) begin errors++; $display("FAIL rd_bw_count: got %0d expected 2", bw_n - wb); end
    checks++; if (bw_tag[wb] !== 8'h06 || bw_addr[wb] !== 6'd0 || bw_data[wb] !== {64{8'hAA}}) begin
      errors++; $display("FAIL rd_half0: got tag %0h addr %0d data %h expected 06 0 aa..", bw_tag[wb], bw_addr[wb], bw_data[wb]);
    end
    checks++; if (bw_tag[wb+1] !== 8'h06 || bw_addr[wb+1] !== 6'd1 || bw_data[wb+1] !== {64{8'hBB}}) begin
      errors++; $display("FAIL rd_half1: got tag %0h addr %0d data %h expected 06 1 bb..", bw_tag[wb+1], bw_addr[wb+1], bw_data[wb+1]);
    end
  endtask

  task automatic test_errors();
    int c, rb, wb, qb;
    logic [7:0]  tags  [4] = '{8'h21, 8'h22, 8'h23, 8'h24};
    logic [12:0] codes [4] = '{READ, WRITE, 13'h1234, 13'h1234};
    logic [63:0] addrs [4] = '{64'h40, 64'h100, 64'h80, 64'h41};
    logic [11:0] sizes [4] = '{12'd128, 12'd64, 12'd128, 12'd128};
    logic [7:0]  exps  [4] = '{8'h01, 8'h01, 8'h08, 8'h08};
    wb = bw_n; qb = br_n;
    for (int k = 0; k < 4; k++) begin
      rb = rsp_n;
      send_cmd(tags[k], codes[k], addrs[k], sizes[k], c);
      idle_cmd();
      wait_rsp(rb + 1, 20);
      checks++; if (rsp_n - rb !== 1 || rsp_tag[rb] !== tags[k] || rsp_code[rb] !== exps[k]) begin
        errors++; $display("FAIL err_rsp%0d: got n=%0d tag %0h code %0h expected 1 %0h %0h", k, rsp_n - rb, rsp_tag[rb], rsp_code[rb], tags[k], exps[k]);
      end
      checks++; if (rsp_cyc[rb] - c !== 2 || rsp_cred[rb] !== 9'd1) begin
        errors++; $display("FAIL err_timing%0d: got +%0d credits %0d expected +2 1", k, rsp_cyc[rb] - c, rsp_cred[rb]);
      end
    end
    repeat (4) @(posedge clock);
    #1;
    checks++; if (bw_n !== wb || br_n !== qb) begin
      errors++; $display("FAIL err_no_buffer: got %0d writes %0d reads expected 0 0", bw_n - wb, br_n - qb);
    end
  endtask

  task automatic test_wrap();
    int c0, c1, c2, rb, wb;
    rb = rsp_n; wb = bw_n;
    afu_h0 = {16{32'hDEADBEEF}}; afu_h1 = {16{32'h0123ABCD}};
    send_cmd(8'h30, WRITE, 64'h7F80, 12'd128, c0);
    send_cmd(8'h31, READ,  64'h7F80, 12'd128, c1);
    send_cmd(8'h32, READ,  64'h8000, 12'd128, c2);
    idle_cmd();
    wait_rsp(rb + 3, 60);
    checks++; if (rsp_n - rb !== 3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", rsp_n - rb); end
    checks++; if (rsp_tag[rb] !== 8'h30 || rsp_code[rb] !== 8'h00 || rsp_tag[rb+1] !== 8'h31 || rsp_code[rb+1] !== 8'h00) begin
      errors++; $display("FAIL wrap_done: got %0h/%0h %0h/%0h expected 30/00 31/00", rsp_tag[rb], rsp_code[rb], rsp_tag[rb+1], rsp_code[rb+1]);
    end
    checks++; if (rsp_tag[rb+2] !== 8'h32 || rsp_code[rb+2] !== 8'h01 || rsp_cyc[rb+2] - c0 !== 12) begin
      errors++; $display("FAIL wrap_high_addr: got %0h/%0h at +%0d expected 32/01 +12", rsp_tag[rb+2], rsp_code[rb+2], rsp_cyc[rb+2] - c0);
    end
    checks++; if (bw_n - wb !== 2 || bw_data[wb] !== {16{32'hDEADBEEF}} || bw_data[wb+1] !== {16{32'h0123ABCD}}) begin
      errors++; $display("FAIL wrap_data: got n=%0d %h expected 2 deadbeef..", bw_n - wb, bw_data[wb]);
    end
  endtask

  task automatic test_fifo_full();
    int c, c0, rb;
    rb = rsp_n;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    for (int i = 0; i < 21; i++) begin
      send_cmd(8'(8'h40 + i), WRITE, 64'(16 + i) << 7, 12'd128, c);
      if (i == 0) c0 = c;
      // cycle c0+19 pushed into a full FIFO while popping: must not flag
      if (i == 20) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_push_pop_full: got %b expected 0", overflow); end
      end
    end
    idle_cmd();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    wait_rsp(rb + 20, 250);
    repeat (20) @(posedge clock);
    #1;
    checks++; if (rsp_n - rb !== 20) begin errors++; $display("FAIL ovf_rsp_count: got %0d expected 20", rsp_n - rb); end
    for (int j = 0; j < 20; j++) begin
      checks++; if (rsp_tag[rb+j] !== 8'(8'h40 + j) || rsp_code[rb+j] !== 8'h00) begin
        errors++; $display("FAIL ovf_order%0d: got %0h/%0h expected %0h/00", j, rsp_tag[rb+j], rsp_code[rb+j], 8'(8'h40 + j));
      end
    end
    checks++; if (room !== 8'd16) begin errors++; $display("FAIL ovf_room: got %0d expected 16", room); end
  endtask

  task automatic test_reset_mid();
    int c, rb, wb;
    rb = rsp_n;
    afu_h0 = {64{8'h11}}; afu_h1 = {64{8'h22}};
    send_cmd(8'h50, WRITE, 64'h1000, 12'd128, c);
    idle_cmd();
    wait_rsp(rb + 1, 30);
    checks++; if (rsp_n - rb !== 1 || rsp_tag[rb] !== 8'h50) begin
      errors++; $display("FAIL rm_setup: got n=%0d tag %0h expected 1 50", rsp_n - rb, rsp_tag[rb]);
    end
    rb = rsp_n;
    afu_h0 = {64{8'h33}}; afu_h1 = {64{8'h44}};
    send_cmd(8'h51, WRITE, 64'h1000, 12'd128, c);
    idle_cmd();
    repeat (3) @(posedge clock);
    #1;
    rstn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rstn = 1'b1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_ovf_clear: got %b expected 0", overflow); end
    repeat (20) @(posedge clock);
    #1;
    checks++; if (rsp_n !== rb) begin errors++; $display("FAIL rm_no_rsp: got %0d responses expected 0", rsp_n - rb); end
    wb = bw_n;
    afu_h0 = '0; afu_h1 = '0;
    send_cmd(8'h52, READ, 64'h1000, 12'd128, c);
    idle_cmd();
    wait_rsp(rb + 1, 30);
    checks++; if (rsp_n - rb !== 1 || rsp_tag[rb] !== 8'h52 || rsp_code[rb] !== 8'h00) begin
      errors++; $display("FAIL rm_read_rsp: got n=%0d %0h/%0h expected 1 52/00", rsp_n - rb, rsp_tag[rb], rsp_code[rb]);
    end
    checks++; if (bw_n - wb !== 2 || bw_data[wb] !== {64{8'h11}} || bw_data[wb+1] !== {64{8'h22}}) begin
      errors++; $display("FAIL rm_line_kept: got n=%0d %h expected 2 11..", bw_n - wb, bw_data[wb]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_wrap();
    test_fifo_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
